// File: rtl/ysyx_24090018_sram_resp_pkg.sv
// Shared constants for the SRAM responder slice.
//   SRAM_IDLE/SRAM_WAIT/SRAM_RESP : 2-bit FSM state codes
//   LFSR_SEED                     : reset value of the delay randomiser
//   lfsr8_next()                  : one step of x^8+x^6+x^5+x^4+1 (Fibonacci, shift left)
package ysyx_24090018_sram_resp_pkg;

    localparam logic [1:0] SRAM_IDLE = 2'd0;
    localparam logic [1:0] SRAM_WAIT = 2'd1;
    localparam logic [1:0] SRAM_RESP = 2'd2;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Taps at bit positions 7,5,4,3 correspond to x^8, x^6, x^5, x^4.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/ysyx_24090018_lfsr8.sv
// 8-bit LFSR used to randomise the SRAM response delay.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-low; loads LFSR_SEED
//   en  : advance one step this cycle
//   q   : current LFSR value
module ysyx_24090018_lfsr8
    import ysyx_24090018_sram_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr8_next(q);
        end
    end

endmodule

// File: rtl/ysyx_24090018_sram_resp.sv
// Memory-side responder: serves one load/store at a time from a word RAM
// after a fixed or pseudo-random delay.
//   clk, rst             : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_wen/addr/wdata/wstrb : request payload
//   rsp_valid/rsp_ready  : response handshake (valid only in RESP)
//   rsp_rdata/rsp_err    : load data (0 for stores/errors), out-of-window flag
//   dbg_state            : current FSM state code
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. req_ready is a pure function of state (never of req_valid); once
// rsp_valid is raised the response payload stays stable until it is taken, and
// the responder returns to IDLE, so no request is accepted on the same edge as
// a response handshake.
module ysyx_24090018_sram_resp
    import ysyx_24090018_sram_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2,
    parameter int                    RAND_DELAY = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [1:0]              dbg_state
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WORDS  = 1 << DEPTH_LOG2;

    logic [1:0]              state;
    logic [4:0]              cnt;
    logic                    lat_wen;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [STRB_W-1:0]       lat_wstrb;

    logic [DATA_WIDTH-1:0]   mem [0:WORDS-1];

    logic [7:0]              lfsr_q;
    logic [4:0]              rand_add;
    logic [4:0]              delay;
    logic                    accept;
    logic                    do_access;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    in_range;
    logic                    unused_bits;

    assign req_ready = (state == SRAM_IDLE);
    assign rsp_valid = (state == SRAM_RESP);
    assign dbg_state = state;
    assign accept    = req_valid & req_ready;
    assign do_access = (state == SRAM_WAIT) && (cnt == 5'd0);

    generate
        if (RAND_DELAY != 0) begin : g_rand
            ysyx_24090018_lfsr8 u_lfsr (
                .clk (clk),
                .rst (rst),
                .en  (accept),
                .q   (lfsr_q)
            );
            assign rand_add = {3'b000, lfsr_q[1:0]};
        end else begin : g_fixed
            assign lfsr_q   = LFSR_SEED;
            assign rand_add = 5'd0;
        end
    endgenerate

    // Delay is taken from the LFSR value present at accept time, before it steps.
    assign delay = 5'(LATENCY) + rand_add;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets and
    // are additionally excluded by the explicit compare.
    assign offset   = lat_addr - BASE_ADDR;
    assign idx      = offset[DEPTH_LOG2+1:2];
    assign in_range = (lat_addr >= BASE_ADDR) &&
                      (offset[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);

    // Byte offset within the word and upper LFSR bits carry no meaning here.
    assign unused_bits = ^{offset[1:0], lfsr_q[7:2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SRAM_IDLE;
            cnt       <= 5'd0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                SRAM_IDLE: begin
                    if (req_valid) begin
                        state     <= SRAM_WAIT;
                        cnt       <= delay - 5'd1;
                        lat_wen   <= req_wen;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                    end
                end
                SRAM_WAIT: begin
                    if (cnt == 5'd0) begin
                        state     <= SRAM_RESP;
                        rsp_rdata <= (!lat_wen && in_range) ? mem[idx] : '0;
                        rsp_err   <= !in_range;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                SRAM_RESP: begin
                    if (rsp_ready) begin
                        state <= SRAM_IDLE;
                    end
                end
                default: state <= SRAM_IDLE;
            endcase
        end
    end

    // RAM is not reset; the write happens on the WAIT->RESP edge only, so a
    // reset while still waiting drops the store.
    always_ff @(posedge clk) begin
        if (do_access && lat_wen && in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (lat_wstrb[i]) begin
                    mem[idx][i*8 +: 8] <= lat_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090018_sram_resp.sv
module tb_ysyx_24090018_sram_resp;

    logic        clk;
    logic        rst;

    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    logic        r_req_valid;
    logic        r_req_ready;
    logic        r_req_wen;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;
    logic [3:0]  r_req_wstrb;
    logic        r_rsp_valid;
    logic        r_rsp_ready;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [1:0]  r_dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;

    ysyx_24090018_sram_resp dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    ysyx_24090018_sram_resp #(.RAND_DELAY(1)) dut_rand (
        .clk       (clk),
        .rst       (rst),
        .req_valid (r_req_valid),
        .req_ready (r_req_ready),
        .req_wen   (r_req_wen),
        .req_addr  (r_req_addr),
        .req_wdata (r_req_wdata),
        .req_wstrb (r_req_wstrb),
        .rsp_valid (r_rsp_valid),
        .rsp_ready (r_rsp_ready),
        .rsp_rdata (r_rsp_rdata),
        .rsp_err   (r_rsp_err),
        .dbg_state (r_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- driver ----------------
    // Full transaction on the fixed-latency DUT. lat = edges from the accept
    // edge until rsp_valid is seen high.
    task automatic send(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
        int n;
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout addr=%h req_ready=%b expected 1", addr, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks += 5;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h expected 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b expected 0", rsp_err); end
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d expected 0", dbg_state); end
    endtask

    task automatic test_latency();
        logic [31:0] d; logic e; int lat;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL latency_ready got %b expected 1", req_ready); end
        send(1'b0, 32'h8000_0000, 32'h0, 4'h0, d, e, lat);
        checks += 2;
        if (lat !== 2) begin errors++; $display("FAIL latency_edges got %0d expected 2", lat); end
        if (e !== 1'b0) begin errors++; $display("FAIL latency_err got %b expected 0", e); end
    endtask

    task automatic test_store_merge();
        logic [31:0] d; logic e; int lat;
        send(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, d, e, lat);
        send(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, d, e, lat);
        checks += 2;
        if (d !== 32'h0) begin errors++; $display("FAIL store_rdata got %h expected 0", d); end
        if (e !== 1'b0) begin errors++; $display("FAIL store_err got %b expected 0", e); end
        send(1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010, d, e, lat);
        send(1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, d, e, lat);
        checks += 2;
        if (d !== 32'hDEAD_55EF) begin errors++; $display("FAIL merge_load got %h expected deadbeef-merged dead55ef", d); end
        if (e !== 1'b0) begin errors++; $display("FAIL merge_err got %b expected 0", e); end
        send(1'b0, 32'h8000_0000, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL word0_load got %h expected cafef00d", d); end
    endtask

    task automatic test_backpressure();
        int n;
        req_wen = 1'b0; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_wstrb = 4'h0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        // second request held by the initiator for the whole response phase
        req_wen = 1'b1; req_addr = 32'h8000_0FFC; req_wdata = 32'h1122_3344; req_wstrb = 4'hF;
        wait_rsp(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL bp_latency got %0d expected 2", n); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks += 4;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got %b expected 1", i, rsp_valid); end
            if (rsp_rdata !== 32'hDEAD_55EF) begin errors++; $display("FAIL bp_rdata cyc=%0d got %h expected dead55ef", i, rsp_rdata); end
            if (rsp_err !== 1'b0) begin errors++; $display("FAIL bp_err cyc=%0d got %b expected 0", i, rsp_err); end
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc=%0d got %b expected 0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks += 3;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL bp_after_hs_state got %0d expected 0", dbg_state); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs_valid got %b expected 0", rsp_valid); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs_ready got %b expected 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL bp_next_accept_state got %0d expected 1", dbg_state); end
        wait_rsp(n);
        checks += 2;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL bp_store_rdata got %h expected 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL bp_store_err got %b expected 0", rsp_err); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic e; int lat;
        send(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, d, e, lat);
        checks += 2;
        if (e !== 1'b1) begin errors++; $display("FAIL oor_low_err got %b expected 1", e); end
        if (d !== 32'h0) begin errors++; $display("FAIL oor_low_rdata got %h expected 0", d); end
        send(1'b1, 32'h8000_1000, 32'h0BAD_BEEF, 4'hF, d, e, lat);
        checks += 2;
        if (e !== 1'b1) begin errors++; $display("FAIL oor_high_err got %b expected 1", e); end
        if (d !== 32'h0) begin errors++; $display("FAIL oor_high_rdata got %h expected 0", d); end
        send(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, d, e, lat);
        checks += 2;
        if (d !== 32'h1122_3344) begin errors++; $display("FAIL last_word got %h expected 11223344", d); end
        if (e !== 1'b0) begin errors++; $display("FAIL last_word_err got %b expected 0", e); end
        send(1'b0, 32'h8000_0000, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_alias_word0 got %h expected cafef00d", d); end
        send(1'b0, 32'h8000_1000, 32'h0, 4'h0, d, e, lat);
        checks += 2;
        if (e !== 1'b1) begin errors++; $display("FAIL oor_load_err got %b expected 1", e); end
        if (d !== 32'h0) begin errors++; $display("FAIL oor_load_rdata got %h expected 0", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int lat; int n;
        send(1'b1, 32'h8000_0020, 32'h0102_0304, 4'hF, d, e, lat);
        // reset while the store sits in WAIT
        req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rst_wait_pre_state got %0d expected 1", dbg_state); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_wait_state got %0d expected 0", dbg_state); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid got %b expected 0", rsp_valid); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send(1'b0, 32'h8000_0020, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h0102_0304) begin errors++; $display("FAIL rst_wait_old_value got %h expected 01020304", d); end
        // reset while a store sits in RESP: it is already committed
        req_wen = 1'b1; req_addr = 32'h8000_0024; req_wdata = 32'h55AA_55AA; req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(n);
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b expected 0", rsp_valid); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send(1'b0, 32'h8000_0024, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h55AA_55AA) begin errors++; $display("FAIL rst_resp_committed got %h expected 55aa55aa", d); end
    endtask

    task automatic test_rand_delay();
        logic [7:0] lfsr;
        int exp_d;
        int lat;
        int n;
        apply_reset();
        lfsr = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            exp_d = 2 + int'(lfsr[1:0]);
            r_req_wen = 1'b0; r_req_addr = 32'h8000_0000 + 32'(i * 4);
            r_req_wdata = 32'h0; r_req_wstrb = 4'h0;
            r_req_valid = 1'b1;
            n = 0;
            while (!r_req_ready && n < 50) begin
                @(posedge clk); #1; n++;
            end
            @(posedge clk); #1;
            r_req_valid = 1'b0;
            lat = 0;
            while (!r_rsp_valid && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            checks += 3;
            if (lat !== exp_d) begin errors++; $display("FAIL rand_delay i=%0d got %0d expected %0d", i, lat, exp_d); end
            if (lat < 2 || lat > 5) begin errors++; $display("FAIL rand_range i=%0d got %0d expected 2..5", i, lat); end
            if (r_rsp_err !== 1'b0) begin errors++; $display("FAIL rand_err i=%0d got %b expected 0", i, r_rsp_err); end
            r_rsp_ready = 1'b1;
            @(posedge clk); #1;
            r_rsp_ready = 1'b0;
            lfsr = {lfsr[6:0], ^(lfsr & 8'b1011_1000)};
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0;
        r_req_valid = 1'b0; r_req_wen = 1'b0; r_req_addr = '0; r_req_wdata = '0; r_req_wstrb = '0;
        r_rsp_ready = 1'b0;
        test_reset();
        test_latency();
        test_store_merge();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_rand_delay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
